// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-low glyph table for hex nibbles,
// blank pattern and bus widths used by both the display and readback paths.
package seg7_pkg;

  localparam int SEG_W  = 7;
  localparam int NIB_W  = 4;
  localparam int DIG_N  = 4;
  localparam int WORD_W = NIB_W * DIG_N;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Active-low g..a, indexed by nibble value
  localparam logic [SEG_W-1:0] SEG_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct packed {
    logic             valid;
    logic [NIB_W-1:0] nib;
  } unlut_t;

endpackage

// File: rtl/seg7_decode_4_if.sv
// Multiplexed seven-segment bus plus the decoded-word outputs of the readback block.
interface seg7_decode_4_if;
  import seg7_pkg::*;

  logic [SEG_W-1:0]  iSEG;
  logic [DIG_N-1:0]  iDIGSEL;
  logic [WORD_W-1:0] oDIG;
  logic              oVALID;
  logic              oERR;

  modport master (output iSEG, iDIGSEL, input oDIG, oVALID, oERR);
  modport slave  (input iSEG, iDIGSEL, output oDIG, oVALID, oERR);

endinterface

// File: rtl/seg7_unlut.sv
// Reverse glyph lookup: active-low segment pattern to {valid, nibble}.
module seg7_unlut
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output unlut_t           res_o
);

  // Unknown patterns fall through as nibble 0 with valid low
  always_comb begin
    res_o = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg_i == SEG_PAT[i]) begin
        res_o.valid = 1'b1;
        res_o.nib   = NIB_W'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_decode_4.sv
// Samples a multiplexed 4-digit seven-segment bus, filters glitches and
// reassembles the displayed digits into a 16-bit word with a valid strobe.
module seg7_decode_4
  import seg7_pkg::*;
#(
  parameter int STABLE_CYC = 16
) (
  input  logic iCLK,
  input  logic iRST,
  seg7_decode_4_if.slave bus
);

  localparam int SMP_W = SEG_W + DIG_N;
  localparam int CNT_W = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(STABLE_CYC - 2);

  logic [SMP_W-1:0]  sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              match, commit;

  logic [DIG_N-1:0]  sel_n;
  logic [SEG_W-1:0]  seg;
  logic              sel_one, sel_multi;
  logic [1:0]        idx;
  unlut_t            dec;

  logic [WORD_W-1:0] word_q, word_d, word_upd;
  logic [DIG_N-1:0]  mask_q, mask_d, mask_upd;
  logic              acc_q, acc_d;
  logic [WORD_W-1:0] dig_q, dig_d;
  logic              err_q, err_d;
  logic              valid_q, valid_d;

  assign match = (sync2_q == prev_q);

  // Commit fires on the cycle the counter would reach its ceiling, once per stable period
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    commit = 1'b0;
    if (!match) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else begin
      if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_PRE && !done_q) begin
        commit = 1'b1;
        done_d = 1'b1;
      end
    end
  end

  assign sel_n     = ~sync2_q[SMP_W-1:SEG_W];
  assign seg       = sync2_q[SEG_W-1:0];
  assign sel_one   = (sel_n != '0) && ((sel_n & (sel_n - 4'd1)) == '0);
  assign sel_multi = (sel_n != '0) && !sel_one;

  always_comb begin
    idx = '0;
    for (int k = 0; k < DIG_N; k++) begin
      if (sel_n[k]) idx = 2'(k);
    end
  end

  seg7_unlut u_unlut (
    .seg_i (seg),
    .res_o (dec)
  );

  always_comb begin
    word_upd = word_q;
    word_upd[{idx, 2'b00} +: NIB_W] = dec.nib;
    mask_upd = mask_q;
    mask_upd[idx] = 1'b1;

    word_d  = word_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    dig_d   = dig_q;
    err_d   = err_q;
    valid_d = 1'b0;

    if (commit && sel_multi) begin
      acc_d = 1'b1;
    end else if (commit && sel_one) begin
      word_d = word_upd;
      if (mask_upd == '1) begin
        dig_d   = word_upd;
        err_d   = acc_q | ~dec.valid;
        valid_d = 1'b1;
        mask_d  = '0;
        acc_d   = 1'b0;
      end else begin
        mask_d = mask_upd;
        acc_d  = acc_q | ~dec.valid;
      end
    end
  end

  // Synchronisers idle at all-ones: blank segments, no digit selected
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      word_q  <= '0;
      mask_q  <= '0;
      acc_q   <= 1'b0;
      dig_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync1_q <= {bus.iDIGSEL, bus.iSEG};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      dig_q   <= dig_d;
      err_q   <= err_d;
      valid_q <= valid_d;
    end
  end

  assign bus.oDIG   = dig_q;
  assign bus.oERR   = err_q;
  assign bus.oVALID = valid_q;

endmodule

// File: tb/tb_seg7_decode_4.sv
// Bench for seg7_decode_4: table frames, hand corner sequences and random frames
// checked against a step-level behavioural model of the readback path.
module tb_seg7_decode_4;

  localparam int STABLE = 16;

  localparam logic [6:0] TB_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  logic iCLK = 1'b0;
  logic iRST = 1'b1;

  seg7_decode_4_if bus ();

  seg7_decode_4 #(.STABLE_CYC(STABLE)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Behavioural model: tracks how long each bus value is held, commits once per
  // sufficiently long hold and queues each completed frame.
  typedef struct { logic [15:0] w; logic e; } frm_t;
  frm_t        exp_q[$];
  logic [15:0] m_word;
  logic [3:0]  m_mask;
  logic        m_err;
  logic [10:0] m_prev;
  int          m_run;
  bit          m_done;

  task automatic model_reset();
    m_word = '0; m_mask = '0; m_err = 1'b0;
    m_prev = 11'h7FF; m_run = 0; m_done = 1'b1;
    exp_q.delete();
  endtask

  task automatic model_commit(input logic [3:0] sel, input logic [6:0] seg);
    int lows = 0;
    int dig = 0;
    int nib = 0;
    bit found = 0;
    frm_t f;
    for (int k = 0; k < 4; k++) if (!sel[k]) begin lows++; dig = k; end
    if (lows == 0) return;
    if (lows > 1) begin m_err = 1'b1; return; end
    for (int i = 0; i < 16; i++) if (TB_PAT[i] == seg) begin nib = i; found = 1; end
    m_word[dig*4 +: 4] = 4'(nib);
    m_mask[dig] = 1'b1;
    if (!found) m_err = 1'b1;
    if (m_mask == 4'hF) begin
      f.w = m_word; f.e = m_err;
      exp_q.push_back(f);
      m_mask = '0; m_err = 1'b0;
    end
  endtask

  task automatic model_step(input logic [3:0] sel, input logic [6:0] seg, input int n);
    logic [10:0] v = {sel, seg};
    if (v == m_prev) m_run += n;
    else begin m_run = n; m_done = 1'b0; m_prev = v; end
    if (!m_done && m_run >= STABLE) begin
      m_done = 1'b1;
      model_commit(sel, seg);
    end
  endtask

  task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
    model_step(sel, seg, n);
    bus.iDIGSEL = sel;
    bus.iSEG    = seg;
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  function automatic logic [3:0] dsel(input int k);
    logic [3:0] s = 4'hF;
    s[k] = 1'b0;
    return s;
  endfunction

  task automatic flush();
    drive(4'hF, 7'h7F, 30);
  endtask

  // Output monitor
  int          vcount = 0;
  logic [15:0] last_w = '0;
  logic        last_e = 1'b0;
  logic        prev_v = 1'b0;

  always @(negedge iCLK) begin
    if (iRST) prev_v = 1'b0;
    else begin
      if (bus.oVALID) begin
        frm_t f;
        chk("valid_back_to_back", 32'(prev_v), 32'd0);
        vcount++;
        last_w = bus.oDIG;
        last_e = bus.oERR;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid got_word=%h expected_none", bus.oDIG);
        end else begin
          f = exp_q.pop_front();
          chk("model_word", 32'(bus.oDIG), 32'(f.w));
          chk("model_err", 32'(bus.oERR), 32'(f.e));
        end
      end
      prev_v = bus.oVALID;
    end
  end

  typedef struct {
    logic [3:0][6:0] pats;
    logic [15:0]     exp_w;
    logic            exp_e;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int c0;
    int order[4];

    vecs[0].pats = {TB_PAT[4], TB_PAT[3], TB_PAT[2], TB_PAT[1]};
    vecs[0].exp_w = 16'h4321; vecs[0].exp_e = 1'b0;
    vecs[1].pats = {TB_PAT[4], 7'b1010101, TB_PAT[2], TB_PAT[1]};
    vecs[1].exp_w = 16'h4021; vecs[1].exp_e = 1'b1;
    vecs[2].pats = {TB_PAT[11], TB_PAT[14], TB_PAT[14], TB_PAT[15]};
    vecs[2].exp_w = 16'hBEEF; vecs[2].exp_e = 1'b0;
    vecs[3].pats = {7'h7F, TB_PAT[3], TB_PAT[2], TB_PAT[1]};
    vecs[3].exp_w = 16'h0321; vecs[3].exp_e = 1'b1;

    model_reset();
    bus.iSEG = 7'h7F;
    bus.iDIGSEL = 4'hF;
    repeat (3) @(posedge iCLK);
    #1;
    chk("reset_dig", 32'(bus.oDIG), 32'h0);
    chk("reset_valid", 32'(bus.oVALID), 32'h0);
    chk("reset_err", 32'(bus.oERR), 32'h0);
    iRST = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;

    for (int v = 0; v < 4; v++) begin
      c0 = vcount;
      for (int k = 0; k < 4; k++) drive(dsel(k), vecs[v].pats[k], 20);
      flush();
      chk("tbl_valid_count", 32'(vcount - c0), 32'd1);
      chk("tbl_word", 32'(last_w), 32'(vecs[v].exp_w));
      chk("tbl_err", 32'(last_e), 32'(vecs[v].exp_e));
    end

    // glitch to 8 on digit 0 must not be captured
    c0 = vcount;
    drive(dsel(0), TB_PAT[5], 20);
    drive(dsel(0), TB_PAT[8], 8);
    drive(dsel(0), TB_PAT[5], 20);
    drive(dsel(1), TB_PAT[6], 20);
    drive(dsel(2), TB_PAT[7], 20);
    drive(dsel(3), TB_PAT[9], 20);
    flush();
    chk("glitch_valid_count", 32'(vcount - c0), 32'd1);
    chk("glitch_word", 32'(last_w), 32'h9765);
    chk("glitch_err", 32'(last_e), 32'h0);

    // long hold on one digit commits once
    c0 = vcount;
    drive(dsel(0), TB_PAT[7], 200);
    chk("hold_no_valid", 32'(vcount - c0), 32'd0);
    chk("hold_mask", 32'(dut.mask_q), 32'h1);
    drive(dsel(1), TB_PAT[10], 20);
    drive(dsel(2), TB_PAT[11], 20);
    drive(dsel(3), TB_PAT[12], 20);
    flush();
    chk("hold_valid_count", 32'(vcount - c0), 32'd1);
    chk("hold_word", 32'(last_w), 32'hCBA7);

    // random frames against the model
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 4; k++) order[k] = k;
      for (int k = 3; k > 0; k--) begin
        int j = $urandom_range(0, k);
        int t = order[k];
        order[k] = order[j];
        order[j] = t;
      end
      for (int k = 0; k < 4; k++) begin
        logic [6:0] sg = TB_PAT[$urandom_range(0, 15)];
        case ($urandom_range(0, 11))
          0: sg = 7'h55;
          1: sg = 7'h2A;
          2: sg = 7'h7F;
          default: ;
        endcase
        if ($urandom_range(0, 3) == 0)
          drive(dsel(order[k]), TB_PAT[$urandom_range(0, 15)], $urandom_range(1, 8));
        drive(dsel(order[k]), sg, $urandom_range(20, 28));
        if ($urandom_range(0, 3) == 0)
          drive(4'hF, 7'h7F, ($urandom_range(0, 1) == 1) ? 24 : $urandom_range(1, 6));
      end
      flush();
    end
    chk("random_all_frames_seen", 32'(exp_q.size()), 32'd0);

    // multi-select mid frame flags the frame
    c0 = vcount;
    drive(dsel(0), TB_PAT[1], 20);
    drive(4'b0011, TB_PAT[2], 20);
    drive(dsel(1), TB_PAT[2], 20);
    drive(dsel(2), TB_PAT[3], 20);
    drive(dsel(3), TB_PAT[4], 20);
    flush();
    chk("multi_valid_count", 32'(vcount - c0), 32'd1);
    chk("multi_word", 32'(last_w), 32'h4321);
    chk("multi_err", 32'(last_e), 32'h1);

    // reset after three digits discards the partial frame
    drive(dsel(0), TB_PAT[9], 20);
    drive(dsel(1), TB_PAT[9], 20);
    drive(dsel(2), TB_PAT[9], 20);
    drive(4'hF, 7'h7F, 10);
    iRST = 1'b1;
    #1;
    chk("async_reset_dig", 32'(bus.oDIG), 32'h0);
    chk("async_reset_err", 32'(bus.oERR), 32'h0);
    chk("async_reset_valid", 32'(bus.oVALID), 32'h0);
    repeat (2) @(posedge iCLK);
    #1;
    iRST = 1'b0;
    model_reset();
    c0 = vcount;
    drive(dsel(0), TB_PAT[3], 20);
    drive(dsel(1), TB_PAT[12], 20);
    drive(dsel(2), TB_PAT[5], 20);
    drive(dsel(3), TB_PAT[10], 20);
    flush();
    chk("post_reset_valid_count", 32'(vcount - c0), 32'd1);
    chk("post_reset_word", 32'(last_w), 32'hA5C3);
    chk("post_reset_err", 32'(last_e), 32'h0);
    chk("final_pending", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_decode_4.md
# seg7_decode_4

Receive-side counterpart of the four-digit seven-segment display path. Samples an externally driven, time-multiplexed seven-segment bus (active-low segments plus active-low digit selects), filters glitches, and decodes each digit's pattern back to a hex nibble. Once all four digits have been captured, it presents a 16-bit word with a one-cycle valid strobe and an error flag. Used to read back or monitor display data driven by another board or controller.

## Interface
- STABLE_CYC, 16: cycles a sampled segment/select pair must stay unchanged before it is accepted (≥2).
- iCLK  in  1  system clock.
- iRST  in  1  reset, asynchronous, active-high.
- iSEG  in  7  segment lines, active-low (0 = lit), bit0 = a … bit6 = g; asynchronous to iCLK.
- iDIGSEL  in  4  digit selects, active-low, bit k selects digit k; asynchronous to iCLK.
- oDIG  out  16  last complete word; digit k in bits [4k+3:4k]; holds until the next frame.
- oVALID  out  1  one-cycle pulse when oDIG/oERR update.
- oERR  out  1  set with oVALID if any digit in that frame had an unrecognised pattern; holds with oDIG.

## Operation
- Synchroniser: iSEG and iDIGSEL pass through a 2-flop synchroniser, 11 bits total.
- Stability filter:
  - Register the previous synchronised sample.
  - On a mismatch, counter <= 0 and clear the committed flag.
  - On a match, counter increments, saturating at STABLE_CYC-1.
  - Commit occurs in the cycle the counter reaches STABLE_CYC-1 with the committed flag clear. The committed flag is then set, so each stable period commits once.
- Commit classification on the sampled iDIGSEL:
  - Exactly one bit low (digit k): decode the segments.
  - All high (blanking): ignore.
  - More than one bit low: ignore, and set the frame error accumulator.
- Decode table (active-low, g..a), nibble 0–F:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0011000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
  - Any other pattern, including all-off 1111111, decodes to nibble 0 and sets the error accumulator.
- Frame assembly:
  - Digit commit writes nibble[k] and sets mask[k]. Re-committing a digit before the frame completes overwrites nibble[k].
  - When a commit makes mask = 4'b1111, on the same clock edge:
    - oDIG <= assembled word including the new nibble.
    - oERR <= accumulator OR this commit's error.
    - oVALID <= 1.
    - mask <= 0 and accumulator <= 0.
- No handshake back-pressure. A consumer that misses oVALID reads the held oDIG/oERR.

## Timing
- Reset values:
  - oDIG = 16'h0000, oVALID = 0, oERR = 0.
  - mask = 0, accumulator = 0, counter = 0, committed flag = 0, synchronisers all ones (idle = blank, nothing selected).
- Latency:
  - Input change to commit: 2 sync cycles + STABLE_CYC cycles of stability.
  - Commit to oVALID high: 1 cycle, registered.
- oVALID is never high on two consecutive cycles. A new frame needs at least 4 commits × STABLE_CYC cycles.
- Glitch shorter than STABLE_CYC cycles: no commit; the counter restarts.
- A select held indefinitely commits once only. The same digit is not re-captured until the pattern or select changes and is stable again.
- Reset asserted mid-frame discards the partial mask, nibbles and accumulator. Outputs return to reset values asynchronously.

## Structure
- Package seg7_pkg:
  - 16-entry active-low pattern constant array, used by the display-side LUT too.
  - SEG_BLANK = 7'h7F.
  - Nibble/segment width constants.
- Sub-module seg7_unlut: combinational 7-bit pattern → {valid, nibble[3:0]} lookup driven by the package table.
- Top holds the synchroniser, stability counter ($clog2(STABLE_CYC) bits), commit logic, mask/nibble registers and output registers.

## Test plan
- Scan digits 0..3 with patterns for 1,2,3,4, each held 20 cycles (STABLE_CYC = 16) -> one oVALID pulse, oDIG = 16'h4321, oERR = 0.
- Same scan with digit 2 driving 1010101 -> oDIG = 16'h4021, oERR = 1; the next clean frame 16'hBEEF -> oERR = 0.
- 8-cycle glitch to pattern 8 on digit 0, which otherwise shows 5 -> no commit of 8; digit 0 reads 5.
- iDIGSEL = 4'b0011 held 20 cycles mid-frame, then a frame completes -> oERR = 1 for that frame.
- Select digit 0 continuously for 200 cycles -> exactly one commit, mask = 0001, no oVALID.
- iRST asserted after 3 digits are committed, then a full frame 16'hA5C3 -> a single oVALID with oDIG = 16'hA5C3; no stale digits appear.
